ir_prefetch_queue: RTL and testbench
====================================

// Module: ir_prefetch_queue
// PURPOSE
//  Parametrised successor to the single instruction register: a DEPTH-entry instruction prefetch queue.
//  Sits between memory read data and the controller/ALU decode path.
//  Splits each queued word into opcode and operand fields.
//  Adds valid/ready handshakes on both sides and a branch flush.
// PARAMETERS
//  DATA_WIDTH   32  fetched instruction word width
//  ADDR_WIDTH   24  operand field width (low bits of word)
//  OPCODE_SIZE   8  opcode field width (high bits); ADDR_WIDTH+OPCODE_SIZE must equal DATA_WIDTH
//  DEPTH         4  queue entries; power of 2, >=2
// PORTS
//  clock        in   1                     clock; all state updates on FALLING edge
//  reset        in   1                     asynchronous, active-low reset
//  fetch_valid  in   1                     memory presents a word on fetch_data
//  fetch_data   in   DATA_WIDTH            fetched instruction word
//  fetch_ready  out  1                     queue accepts a word this cycle
//  flush        in   1                     discard all queued words (branch taken)
//  ir_ready     in   1                     controller consumes the head word
//  ir_valid     out  1                     head word valid
//  opcode_out   out  OPCODE_SIZE           head word [DATA_WIDTH-1 -: OPCODE_SIZE]
//  operand_out  out  ADDR_WIDTH            head word [ADDR_WIDTH-1:0]
//  count        out  $clog2(DEPTH+1)       occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset low: rd/wr pointers=0, count=0, storage don't-care; ir_valid=0, opcode_out=0, operand_out=0, fetch_ready=1.
//  - push = fetch_valid & fetch_ready; pop = ir_valid & ir_ready; both sampled at falling edge.
//  - fetch_ready = (count < DEPTH) & ~flush; does not depend on ir_ready: when full, no push even if a pop occurs the same edge.
//  - ir_valid = (count != 0); opcode_out/operand_out = head entry when ir_valid, else all zeros.
//  - Push latency: word pushed at edge N is visible on outputs after edge N (one falling edge minimum).
//  - Simultaneous push+pop (count 1..DEPTH-1): count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; ordering strictly FIFO across wrap.
//  - flush: at the edge, pointers and count cleared; flush overrides push and pop that edge; queued words lost.
//  - Reset asserted mid-operation: immediate (asynchronous) return to reset values; any in-flight word is dropped.
//  - No overflow/underflow possible by construction; count never exceeds DEPTH.
// CONFIGURATION
//  IR_BYPASS_EN defined: when count==0 and fetch_valid & ~flush, ir_valid=1 combinationally.
//    opcode_out/operand_out are then taken from fetch_data.
//    If ir_ready is also high, the word is consumed without being written (count stays 0).
//    If ir_ready is low, the word is pushed normally.
//  IR_BYPASS_EN undefined: no combinational path fetch_* -> ir_*; minimum latency one edge.
// STRUCTURE
//  Package ir_pkg: default width constants, opcode/operand slice functions, count width function.
//  Sub-module ir_queue_mem: DEPTH x DATA_WIDTH register array.
//    Write port: falling-edge write. Read port: asynchronous read by rd pointer.
//  Top level holds pointers, count, handshake and bypass logic.
// TESTING
//  1 reset low with fetch_valid=1 -> count=0, ir_valid=0, outputs 0; release -> fetch_ready=1.
//  2 push 0x01AAAAAA,0x02BBBBBB,0x03CCCCCC,0x04DDDDDD, ir_ready=0 -> count=4, fetch_ready=0.
//    Then pop -> opcodes 01,02,03,04, operands AAAAAA..DDDDDD in order.
//  3 full (count=4), fetch_valid=1 and ir_ready=1 same edge -> pop only, count=3; next edge push accepted.
//  4 count=2, flush=1 with fetch_valid=1 and ir_ready=1 -> count=0, ir_valid=0, pushed word discarded.
//  5 stream 10 words with random ir_ready -> order preserved across pointer wrap, count never >4.
//  6 IR_BYPASS_EN: empty, fetch_data=0x7F123456, ir_ready=1 -> same cycle opcode_out=0x7F, operand_out=0x123456, count stays 0.
//    Without IR_BYPASS_EN -> ir_valid=0 until next falling edge.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared widths and field helpers for the instruction prefetch queue.
package ir_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 24;
    localparam int DEF_OPCODE_SIZE = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int MAX_WORD        = 64;

    typedef logic [MAX_WORD-1:0] word_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic word_t field_mask(input int size);
        return (word_t'(1) << size) - word_t'(1);
    endfunction

    // Opcode sits in the top OPCODE_SIZE bits of the fetched word
    function automatic word_t opcode_field(input word_t w, input int data_w,
                                           input int size);
        return (w >> (data_w - size)) & field_mask(size);
    endfunction

    function automatic word_t operand_field(input word_t w, input int size);
        return w & field_mask(size);
    endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x DATA_WIDTH storage: falling-edge write, asynchronous read.
module ir_queue_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(negedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch queue with valid/ready on both sides and branch flush.
// Define IR_BYPASS_EN to let an empty queue forward fetch_data combinationally.
module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int OPCODE_SIZE = DEF_OPCODE_SIZE,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CW          = count_width(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [DATA_WIDTH-1:0]  fetch_data,
    output logic                   fetch_ready,
    input  logic                   flush,
    input  logic                   ir_ready,
    output logic                   ir_valid,
    output logic [OPCODE_SIZE-1:0] opcode_out,
    output logic [ADDR_WIDTH-1:0]  operand_out,
    output logic [CW-1:0]          count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_empty;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_empty     = (r_count == '0);
    assign fetch_ready = (r_count < CW'(DEPTH)) & ~flush;

`ifdef IR_BYPASS_EN
    assign w_bypass = w_empty & fetch_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed the same cycle never enters storage
    assign w_push = fetch_valid & fetch_ready & ~(w_bypass & ir_ready);
    assign w_pop  = ~w_empty & ir_ready;

    assign ir_valid = ~w_empty | w_bypass;
    assign w_head   = w_bypass ? fetch_data : w_rd_data;

    assign opcode_out = ir_valid
        ? OPCODE_SIZE'(opcode_field(word_t'(w_head), DATA_WIDTH, OPCODE_SIZE))
        : '0;
    assign operand_out = ir_valid
        ? ADDR_WIDTH'(operand_field(word_t'(w_head), ADDR_WIDTH))
        : '0;
    assign count = r_count;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    ir_queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (fetch_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Scoreboard bench for ir_prefetch_queue: driver models occupancy, monitor checks popped words.
module tb_ir_prefetch_queue;

    localparam int DEPTH = 4;
`ifdef IR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        flush;
    logic        ir_ready;
    logic        ir_valid;
    logic [7:0]  opcode_out;
    logic [23:0] operand_out;
    logic [2:0]  count;

    int          n_vec;
    int          n_bad;
    int          m_cnt;
    logic [31:0] exp_q[$];

    ir_prefetch_queue dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .ir_ready    (ir_ready),
        .ir_valid    (ir_valid),
        .opcode_out  (opcode_out),
        .operand_out (operand_out),
        .count       (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: drive after rising edge, check, update model for the falling edge
    task automatic cycle(input logic v, input logic [31:0] d, input logic rdy,
                         input logic fl, output logic acc);
        logic byp;
        logic pop;
        @(posedge clock);
        #1;
        fetch_valid = v;
        fetch_data  = d;
        ir_ready    = rdy;
        flush       = fl;
        #1;
        byp = BYP && (m_cnt == 0) && v && !fl;
        acc = v && (m_cnt < DEPTH) && !fl;
        pop = (m_cnt != 0) && rdy;
        chk("count", 32'(count), 32'(m_cnt));
        chk("fetch_ready", 32'(fetch_ready), 32'((m_cnt < DEPTH) && !fl));
        chk("ir_valid", 32'(ir_valid), 32'((m_cnt != 0) || byp));
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (acc) exp_q.push_back(d);
            if (!(byp && rdy)) m_cnt = m_cnt + int'(acc) - int'(pop);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (reset && ir_valid && ir_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL pop_empty got word %h%h want none",
                             opcode_out, operand_out);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    chk("opcode", 32'(opcode_out), 32'(w[31:24]));
                    chk("operand", 32'(operand_out), 32'(w[23:0]));
                end
            end
        end
    end

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && m_cnt != 0; i++)
            cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
        chk("drained", 32'(m_cnt), 32'd0);
    endtask

    logic [31:0] words [4];
    logic [15:0] rdy_pat;
    logic        acc;
    int          idx;

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_cnt = 0;
        reset = 1'b0;
        fetch_valid = 1'b1;
        fetch_data = 32'h0A123456;
        flush = 1'b0;
        ir_ready = 1'b0;

        // 1: reset held with a word offered
        @(posedge clock);
        @(posedge clock);
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_opcode", 32'(opcode_out), 32'd0);
        chk("rst_operand", 32'(operand_out), 32'd0);
        fetch_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);

        // 2: fill to full, then pop in order
        words[0] = 32'h01AAAAAA;
        words[1] = 32'h02BBBBBB;
        words[2] = 32'h03CCCCCC;
        words[3] = 32'h04DDDDDD;
        for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b0, 1'b0, acc);
        idle(1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(fetch_ready), 32'd0);
        drain();

        // 3: full with simultaneous offer and pop
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h10000000 + 32'(i), 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h1F0000FF, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h1F0000FF, 1'b0, 1'b0, acc);
        idle(1);
        drain();

        // 4: flush beats push and pop
        cycle(1'b1, 32'h21111111, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h22222222, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h23333333, 1'b1, 1'b1, acc);
        idle(1);

        // 5: ten-word stream across pointer wrap with patterned ready
        rdy_pat = 16'b1011_0010_1101_0110;
        idx = 0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            cycle(1'b1, {8'(8'h30 + idx), 24'(idx * 32'h00111111)},
                  rdy_pat[c % 16], 1'b0, acc);
            if (acc) idx++;
        end
        chk("stream_sent", 32'(idx), 32'd10);
        drain();

        // 6: word offered to an empty queue with ready high
        cycle(1'b1, 32'h7F123456, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        idle(1);

        // asynchronous reset in mid-operation drops queued words
        cycle(1'b1, 32'h41234567, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h42345678, 1'b0, 1'b0, acc);
        @(posedge clock);
        #1;
        fetch_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(ir_valid), 32'd0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
